// File: rtl/gmii_rx_header_parser.sv
// gmii_rx_header_parser
// Ingress stage for one GMII receive port. It checks the preamble and SFD of
// each frame, captures the destination and source MACs, and flags bad frames.
// The raw stream goes through a fixed delay line, so the router sees the
// destination MAC before the first byte of the frame arrives.

module gmii_rx_header_parser #(
    parameter int DELAY = 16,
    parameter int BYTE  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BYTE-1:0] gmii_in_data,
    input  logic            gmii_in_dv,
    input  logic            gmii_in_err,
    output logic [BYTE-1:0] gmii_out_data,
    output logic            gmii_out_dv,
    output logic            gmii_out_err,
    output logic [47:0]     da_mac,
    output logic            da_valid,
    output logic            da_broadcast,
    output logic [47:0]     sa_mac,
    output logic            sa_valid,
    output logic            frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DA       = 3'd2,
        ST_SA       = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_DROP     = 3'd5
    } state_t;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // FSM state and its next-state values
    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_err_sticky;
    logic        w_err_sticky_nxt;

    // The shift registers hold the five earlier bytes of an address. The
    // sixth byte comes directly from the input when the capture happens.
    logic [39:0] r_da_shift;
    logic [39:0] w_da_shift_nxt;
    logic [39:0] r_sa_shift;
    logic [39:0] w_sa_shift_nxt;
    logic [47:0] w_da_capture;
    logic [47:0] w_sa_capture;

    logic        w_da_fire;
    logic        w_sa_fire;
    logic        w_frame_err_nxt;

    // Output registers
    logic [47:0] r_da_mac;
    logic        r_da_valid;
    logic        r_da_broadcast;
    logic [47:0] r_sa_mac;
    logic        r_sa_valid;
    logic        r_frame_err;

    // Delay line: {err, dv, data} per stage
    logic [BYTE+1:0] r_dly [DELAY];

    assign w_da_capture = {r_da_shift, gmii_in_data};
    assign w_sa_capture = {r_sa_shift, gmii_in_data};

    // State register, byte counter, address shifters and the sticky payload error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_err_sticky <= 1'b0;
            r_da_shift   <= 40'd0;
            r_sa_shift   <= 40'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err_sticky <= w_err_sticky_nxt;
            r_da_shift   <= w_da_shift_nxt;
            r_sa_shift   <= w_sa_shift_nxt;
        end
    end

    // Next-state logic for frame delineation, header capture and error detection
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_err_sticky_nxt = r_err_sticky;
        w_da_shift_nxt   = r_da_shift;
        w_sa_shift_nxt   = r_sa_shift;
        w_da_fire        = 1'b0;
        w_sa_fire        = 1'b0;
        w_frame_err_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_err_sticky_nxt = 1'b0;
                if (gmii_in_dv) begin
                    // A first byte that has err set counts as a bad first byte
                    if (!gmii_in_err && (gmii_in_data == PRE_BYTE)) begin
                        w_state_nxt = ST_PREAMBLE;
                        w_cnt_nxt   = 3'd1;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                if (!gmii_in_dv) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = 1'b1;
                end else if (gmii_in_err) begin
                    w_state_nxt = ST_DROP;
                end else if ((gmii_in_data == PRE_BYTE) && (r_cnt < 3'd7)) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end else if (gmii_in_data == SFD_BYTE) begin
                    w_state_nxt = ST_DA;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    // A wrong byte, or an eighth 0x55
                    w_state_nxt = ST_DROP;
                end
            end

            ST_DA: begin
                if (!gmii_in_dv) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = 1'b1;
                end else if (gmii_in_err) begin
                    w_state_nxt = ST_DROP;
                end else begin
                    w_da_shift_nxt = w_da_capture[39:0];
                    if (r_cnt == 3'd5) begin
                        w_da_fire   = 1'b1;
                        w_state_nxt = ST_SA;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end

            ST_SA: begin
                if (!gmii_in_dv) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = 1'b1;
                end else if (gmii_in_err) begin
                    w_state_nxt = ST_DROP;
                end else begin
                    w_sa_shift_nxt = w_sa_capture[39:0];
                    if (r_cnt == 3'd5) begin
                        w_sa_fire   = 1'b1;
                        w_state_nxt = ST_PAYLOAD;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!gmii_in_dv) begin
                    w_state_nxt      = ST_IDLE;
                    w_frame_err_nxt  = r_err_sticky;
                    w_err_sticky_nxt = 1'b0;
                end else if (gmii_in_err) begin
                    w_err_sticky_nxt = 1'b1;
                end else begin
                    w_err_sticky_nxt = r_err_sticky;
                end
            end

            ST_DROP: begin
                if (!gmii_in_dv) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Registered status pulses; the captured addresses hold until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_da_mac       <= 48'd0;
            r_da_valid     <= 1'b0;
            r_da_broadcast <= 1'b0;
            r_sa_mac       <= 48'd0;
            r_sa_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_da_valid  <= w_da_fire;
            r_sa_valid  <= w_sa_fire;
            r_frame_err <= w_frame_err_nxt;
            if (w_da_fire) begin
                r_da_mac       <= w_da_capture;
                r_da_broadcast <= (w_da_capture == BCAST_MAC);
            end else begin
                r_da_mac       <= r_da_mac;
                r_da_broadcast <= r_da_broadcast;
            end
            if (w_sa_fire) begin
                r_sa_mac <= w_sa_capture;
            end else begin
                r_sa_mac <= r_sa_mac;
            end
        end
    end

    // Fixed-length delay line that passes the raw stream through without changing it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_dly[i] <= {(BYTE+2){1'b0}};
            end
        end else begin
            r_dly[0] <= {gmii_in_err, gmii_in_dv, gmii_in_data};
            for (int i = 1; i < DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign gmii_out_data = r_dly[DELAY-1][BYTE-1:0];
    assign gmii_out_dv   = r_dly[DELAY-1][BYTE];
    assign gmii_out_err  = r_dly[DELAY-1][BYTE+1];

    assign da_mac       = r_da_mac;
    assign da_valid     = r_da_valid;
    assign da_broadcast = r_da_broadcast;
    assign sa_mac       = r_sa_mac;
    assign sa_valid     = r_sa_valid;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_gmii_rx_header_parser.sv
// Self-checking bench for gmii_rx_header_parser. The expected delay-line
// output and the expected header/status events are queued when stimulus is
// driven. They are compared cycle by cycle on the falling clock edge.

module tb_gmii_rx_header_parser;

    localparam int DELAY  = 16;
    localparam int EV_RST = 0;
    localparam int EV_DA  = 1;
    localparam int EV_SA  = 2;
    localparam int EV_FE  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [47:0] mac;
        logic        bc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_dv;
    logic        in_err;
    logic [7:0]  out_data;
    logic        out_dv;
    logic        out_err;
    logic [47:0] da_mac;
    logic        da_valid;
    logic        da_broadcast;
    logic [47:0] sa_mac;
    logic        sa_valid;
    logic        frame_err;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [9:0]  sq[$];
    ev_t         evq[$];
    logic        prev_rst = 1'b1;
    bit          chk_en = 1'b0;
    logic [47:0] m_da = 48'd0;
    logic [47:0] m_sa = 48'd0;

    gmii_rx_header_parser #(.DELAY(DELAY), .BYTE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .gmii_in_data  (in_data),
        .gmii_in_dv    (in_dv),
        .gmii_in_err   (in_err),
        .gmii_out_data (out_data),
        .gmii_out_dv   (out_dv),
        .gmii_out_err  (out_err),
        .da_mac        (da_mac),
        .da_valid      (da_valid),
        .da_broadcast  (da_broadcast),
        .sa_mac        (sa_mac),
        .sa_valid      (sa_valid),
        .frame_err     (frame_err)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Cycle index; cycle c is the interval after the c-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [47:0] mac);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.mac  = mac;
        e.bc   = (mac == 48'hFFFF_FFFF_FFFF);
        evq.push_back(e);
    endtask

    // Drive one cycle of input. A reset in the previous cycle leaves the delay line all zeros.
    task automatic drive_cycle(input logic r, input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst     = r;
        in_dv   = dv;
        in_err  = er;
        in_data = d;
        if (prev_rst) begin
            sq.delete();
            for (int i = 0; i < DELAY; i++) sq.push_back(10'd0);
        end
        sq.push_back({er, dv, d});
        prev_rst = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Build a frame, queue its expected events from frame-level rules, then drive it
    task automatic send_frame(input int npre, input logic [7:0] sfd,
                              input logic [47:0] da, input logic [47:0] sa,
                              input int npay, input int err_at, input int dv_len,
                              input int rst_at, input int gap);
        logic [7:0] b[$];
        int  len, s, da_end, sa_end;
        bit  pre_ok, err_in, da_ok, sa_ok;
        for (int i = 0; i < npre; i++) b.push_back(8'h55);
        b.push_back(sfd);
        for (int k = 0; k < 6; k++) b.push_back(da[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) b.push_back(sa[47-8*k -: 8]);
        for (int i = 0; i < npay; i++) b.push_back(8'((i * 13) + 1));
        len    = (dv_len >= 0) ? dv_len : b.size();
        s      = cyc + 1;
        da_end = npre + 6;
        sa_end = npre + 12;
        if (rst_at >= 0) begin
            push_ev(EV_RST, s + rst_at + 1, 48'd0);
            if (len > rst_at + 1) push_ev(EV_FE, s + len + 1, 48'd0);
        end else begin
            pre_ok = (npre >= 1) && (npre <= 7) && (sfd == 8'hD5);
            err_in = (err_at >= 0) && (err_at < len);
            da_ok  = pre_ok && (len > da_end) && !(err_in && (err_at <= da_end));
            sa_ok  = pre_ok && (len > sa_end) && !(err_in && (err_at <= sa_end));
            if (da_ok) push_ev(EV_DA, s + da_end + 1, da);
            if (sa_ok) push_ev(EV_SA, s + sa_end + 1, sa);
            if (!sa_ok || err_in) push_ev(EV_FE, s + len + 1, 48'd0);
        end
        for (int i = 0; i < len; i++) begin
            drive_cycle((i == rst_at) ? 1'b1 : 1'b0, 1'b1, (i == err_at) ? 1'b1 : 1'b0, b[i]);
        end
        idle(gap);
    endtask

    logic [9:0] exp_s;
    ev_t        mev;
    bit         e_da, e_sa, e_fe, e_bc;

    // Scoreboard: compare the stream and the status outputs with the queued expectations
    always @(negedge clk) begin
        if (chk_en) begin
            e_da = 1'b0;
            e_sa = 1'b0;
            e_fe = 1'b0;
            e_bc = 1'b0;
            if (sq.size() == 0) begin
                check("stream_underflow", 64'(sq.size()), 64'd1);
            end else begin
                exp_s = sq.pop_front();
                check("out_stream", {out_err, out_dv, out_data}, exp_s);
            end
            while ((evq.size() > 0) && (evq[0].cyc <= cyc)) begin
                mev = evq.pop_front();
                if (mev.cyc != cyc) check("event_missed", 64'(mev.cyc), 64'(cyc));
                case (mev.kind)
                    EV_RST: begin m_da = 48'd0; m_sa = 48'd0; end
                    EV_DA:  begin e_da = 1'b1; e_bc = mev.bc; m_da = mev.mac; end
                    EV_SA:  begin e_sa = 1'b1; m_sa = mev.mac; end
                    EV_FE:  e_fe = 1'b1;
                    default: ;
                endcase
            end
            check("da_valid", da_valid, e_da);
            if (e_da) check("da_broadcast", da_broadcast, e_bc);
            check("da_mac", da_mac, m_da);
            check("sa_valid", sa_valid, e_sa);
            check("sa_mac", sa_mac, m_sa);
            check("frame_err", frame_err, e_fe);
        end
    end

    initial begin
        rst     = 1'b1;
        in_dv   = 1'b0;
        in_err  = 1'b0;
        in_data = 8'h00;
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        idle(4);

        // Nominal frame
        send_frame(7, 8'hD5, 48'h001122334455, 48'h66778899AABB, 46, -1, -1, -1, 12);
        // Broadcast destination
        send_frame(7, 8'hD5, 48'hFFFFFFFFFFFF, 48'h020000000001, 20, -1, -1, -1, 12);
        // Bad SFD
        send_frame(7, 8'h5D, 48'h0A0B0C0D0E0F, 48'h101112131415, 20, -1, -1, -1, 12);
        // Runt: dv falls after three SA bytes
        send_frame(7, 8'hD5, 48'h00AABBCCDDEE, 48'h123456789ABC, 0, -1, 17, -1, 12);
        // err on the second DA byte
        send_frame(7, 8'hD5, 48'h001122334455, 48'h66778899AABB, 20, 9, -1, -1, 12);
        // err in the payload
        send_frame(7, 8'hD5, 48'h0C0D0E0F1011, 48'h2122232425AA, 20, 25, -1, -1, 12);
        // Back-to-back with a one-cycle gap
        send_frame(7, 8'hD5, 48'h111111111111, 48'h222222222222, 10, -1, -1, -1, 1);
        send_frame(7, 8'hD5, 48'h333333333334, 48'h444444444445, 10, -1, -1, -1, 12);
        // Reset mid-DA while the frame continues, then a normal frame
        send_frame(7, 8'hD5, 48'h001122334455, 48'h66778899AABB, 10, -1, -1, 10, 6);
        send_frame(7, 8'hD5, 48'hA0A1A2A3A4A5, 48'hB0B1B2B3B4B5, 12, -1, -1, -1, 12);
        // Short preamble gives an earlier da_valid
        send_frame(3, 8'hD5, 48'h5A5B5C5D5E5F, 48'h606162636465, 8, -1, -1, -1, 12);
        // Eighth 0x55 is rejected
        send_frame(8, 8'hD5, 48'h010203040506, 48'h070809101112, 8, -1, -1, -1, 12);
        // dv rises with err set
        send_frame(7, 8'hD5, 48'h010203040506, 48'h070809101112, 8, 0, -1, -1, 12);
        // DA captured, error in SA suppresses sa_valid only
        send_frame(7, 8'hD5, 48'hCAFE00000001, 48'hBEEF00000002, 8, 16, -1, -1, 12);

        idle(DELAY + 8);
        check("events_left", 64'(evq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gmii_rx_header_parser.md
# gmii_rx_header_parser

Per-port ingress stage between a GMII receive port and the switch router/MAC-learning logic. Delineates each frame on the raw GMII stream (preamble/SFD check), captures the destination and source MAC addresses, and flags malformed frames. Forwards the stream unchanged through a fixed-length delay line, so the destination MAC is available before the frame's first byte reaches the router.

## Interface
Parameters:
- `DELAY`, default 16: pipeline depth of the stream delay line, in cycles. Legal range 14..64.
- `BYTE`, default 8: GMII data width. Fixed at 8.

Ports:
- `clk` in 1: single clock, GMII byte clock.
- `rst` in 1: reset, synchronous, active-high.
- `gmii_in_data` in 8: receive data.
- `gmii_in_dv` in 1: receive data valid; high for the whole frame, preamble included.
- `gmii_in_err` in 1: receive error.
- `gmii_out_data` out 8: `gmii_in_data` delayed by exactly `DELAY` cycles.
- `gmii_out_dv` out 1: `gmii_in_dv` delayed by `DELAY` cycles.
- `gmii_out_err` out 1: `gmii_in_err` delayed by `DELAY` cycles.
- `da_mac` out 48: captured destination MAC. The first DA byte on the wire lands in [47:40].
- `da_valid` out 1: one-cycle pulse; `da_mac` is valid and holds until the next capture.
- `da_broadcast` out 1: registered with `da_valid`; high when `da_mac == 48'hFFFFFFFFFFFF`.
- `sa_mac` out 48: captured source MAC, same byte order as `da_mac`.
- `sa_valid` out 1: one-cycle pulse. Drives the `mac_valid` field of the learning-path `mac_info_interface`.
- `frame_err` out 1: one-cycle pulse at the end of a bad frame.

## Operation
FSM states: IDLE, PREAMBLE, DA, SA, PAYLOAD, DROP. A 3-bit byte counter `cnt` runs inside the states.

- **IDLE:** on `dv=1`:
  - byte is 0x55 → PREAMBLE, `cnt=1`;
  - any other byte → DROP.
- **PREAMBLE:**
  - `dv=1`, byte 0x55, `cnt<7` → stay, `cnt++`;
  - `dv=1`, byte 0xD5 → DA, `cnt=0`;
  - any other byte, or an eighth 0x55 → DROP;
  - `dv=0` → IDLE with `frame_err`.
- **DA:** shift each byte into `da_shift`, `cnt++`. On the 6th byte:
  - next cycle: `da_mac <= shifted value`, `da_valid=1`, `da_broadcast` computed;
  - state → SA, `cnt=0`.
- **SA:** same as DA, filling `sa_shift`. On the 6th byte: next cycle `sa_mac`/`sa_valid`, state → PAYLOAD.
- **PAYLOAD:** wait for `dv=0`, then go to IDLE. `frame_err` pulses if `err` was seen at any point in the frame.
- **DROP:** wait for `dv=0`, then IDLE with `frame_err=1`.
- **`err=1` during PREAMBLE, DA or SA:** go immediately to DROP. Any not-yet-issued `da_valid`/`sa_valid` is suppressed.
- **`err=1` in PAYLOAD:** latch a sticky error flag, cleared in IDLE.
- **`dv` falls in DA or SA (runt):** IDLE with `frame_err=1`. No `sa_valid`, and no `da_valid` if the DA was incomplete.
- **`dv` rises while `err=1`:** treated as a bad first byte → DROP.
- **Delay line:** a pure shift register of 10 bits × `DELAY`. It never inspects the data and never drops bytes; filtering is the router's job.
- **Reset:**
  - all outputs 0, `da_mac`/`sa_mac` = 0, delay line cleared to 0, FSM → IDLE;
  - reset mid-frame discards the frame with no `frame_err`;
  - after reset, a frame already in progress (`dv` high) is handled from IDLE, where it fails the 0x55 check → DROP → `frame_err` when `dv` falls.

## Timing
- Frame first byte on input at cycle `s`; standard 7×0x55 + 0xD5 preamble.
  - Last DA byte at `s+13` → `da_valid` at `s+14`.
  - Last SA byte at `s+19` → `sa_valid` at `s+20`.
- First output byte at `s+DELAY`. With `DELAY≥14`, `da_valid` is at or before the first output byte.
- A shorter preamble moves `da_valid` earlier.
- `frame_err` is registered: it asserts 1 cycle after the cycle where `dv` is first sampled low.
- `da_valid`, `sa_valid` and `frame_err` are single-cycle pulses. `da_mac`/`sa_mac` hold between captures.
- Back-to-back frames with a 1-cycle `dv=0` gap must parse correctly.

## Test plan
1. **Nominal frame:** 7×0x55, 0xD5, DA 00:11:22:33:44:55, SA 66:77:88:99:AA:BB, 46 payload bytes.
   - `da_valid` at `s+14` with `da_mac=48'h001122334455`, `da_broadcast=0`;
   - `sa_valid` at `s+20` with `sa_mac=48'h66778899AABB`;
   - output stream equals input shifted 16 cycles; no `frame_err`.
2. **Broadcast DA FF:FF:FF:FF:FF:FF:** `da_valid` with `da_broadcast=1`.
3. **Bad SFD (0x5D after 7×0x55):** no `da_valid`/`sa_valid`; `frame_err` pulses 1 cycle after `dv` falls; stream still forwarded unchanged.
4. **Runt (`dv` drops after 3 SA bytes):** `da_valid` seen, no `sa_valid`, `frame_err=1`.
5. **Errors:**
   - `err=1` on the 2nd DA byte → no MAC pulses, `frame_err` at end;
   - `err=1` in payload → both MAC pulses, `frame_err` at end.
6. **Back-to-back and reset:**
   - two frames with a 1-cycle gap → both parsed;
   - `rst` asserted mid-DA → all outputs 0 the next cycle; the following frame parses normally.
